// File: rtl/bbs_pkg.sv
// Shared definitions for the Blum Blum Shub stream generator.
//   - bbs_state_e : generator FSM encoding (IDLE, MUL, WB, HOLD)
//   - DEF_SIZE / DEF_MOD : default state width and Blum modulus (179*227)
//   - bitcnt_width() : width of a counter that must reach OUT_BITS
package bbs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_WB   = 2'd2,
        ST_HOLD = 2'd3
    } bbs_state_e;

    localparam int unsigned DEF_SIZE = 16;
    localparam int unsigned DEF_MOD  = 40633;

    function automatic int unsigned bitcnt_width(input int unsigned out_bits);
        return $clog2(out_bits + 1);
    endfunction

endpackage

// File: rtl/mod_mul_serial.sv
// Bit-serial interleaved modular multiplier: result = a*b mod MOD.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   start      : clears the accumulator and arms SIZE steps (b MSB first)
//   a, b       : operands, must stay stable until done
//   done       : high in the cycle the final step is applied
//   result     : accumulator; holds a*b mod MOD from the cycle after done
// Each step is acc = 2*acc mod MOD, then acc = acc + a mod MOD when b[i] is set;
// both reductions are one conditional subtract because acc and a are < MOD.
module mod_mul_serial
    import bbs_pkg::*;
#(
    parameter int unsigned SIZE = DEF_SIZE,
    parameter int unsigned MOD  = DEF_MOD
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic            done,
    output logic [SIZE-1:0] result
);

    localparam int unsigned IW    = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [SIZE:0] MOD_W = (SIZE + 1)'(MOD);

    logic [SIZE-1:0] acc_q, acc_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            active_q, active_d;

    logic [SIZE:0]   dbl, sum;
    logic [SIZE-1:0] dbl_red, sum_red;

    always_comb begin
        dbl      = {acc_q, 1'b0};
        dbl_red  = SIZE'((dbl >= MOD_W) ? dbl - MOD_W : dbl);
        sum      = {1'b0, dbl_red} + {1'b0, a};
        sum_red  = SIZE'((sum >= MOD_W) ? sum - MOD_W : sum);

        acc_d    = acc_q;
        idx_d    = idx_q;
        active_d = active_q;

        if (start) begin
            acc_d    = '0;
            idx_d    = IW'(SIZE - 1);
            active_d = 1'b1;
        end else if (active_q) begin
            acc_d = b[idx_q] ? sum_red : dbl_red;
            if (idx_q == '0) begin
                active_d = 1'b0;
            end else begin
                idx_d = idx_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q    <= '0;
            idx_q    <= '0;
            active_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            active_q <= active_d;
        end
    end

    assign done   = active_q && (idx_q == '0) && !start;
    assign result = acc_q;

endmodule

// File: rtl/bbs_stream_gen.sv
// Blum Blum Shub pseudo-random bit generator: x(n+1) = x(n)^2 mod MOD.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   seed       : seed value, sampled with seed_load
//   seed_load  : load strobe, accepted in any state (aborts work in progress)
//   out_ready  : consumer accepts out_word (only meaningful in HOLD)
//   out_word   : OUT_BITS collected LSBs, first-generated bit in bit 0
//   out_valid  : out_word valid
//   busy       : iterating (MUL or WB)
//   seed_err   : one-cycle pulse when a seed reduces to 0 or 1
//   state_out  : current x(n)
module bbs_stream_gen
    import bbs_pkg::*;
#(
    parameter int unsigned SIZE     = DEF_SIZE,
    parameter int unsigned MOD      = DEF_MOD,
    parameter int unsigned OUT_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SIZE-1:0]     seed,
    input  logic                seed_load,
    input  logic                out_ready,
    output logic [OUT_BITS-1:0] out_word,
    output logic                out_valid,
    output logic                busy,
    output logic                seed_err,
    output logic [SIZE-1:0]     state_out
);

    localparam int unsigned     CW    = bitcnt_width(OUT_BITS);
    localparam logic [SIZE-1:0] MOD_S = SIZE'(MOD);

    bbs_state_e          state_q, state_d;
    logic [SIZE-1:0]     x_q, x_d;
    logic [OUT_BITS-1:0] word_q, word_d;
    logic [CW-1:0]       bitcnt_q, bitcnt_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;

    logic [SIZE-1:0]     seed_red;
    logic                seed_ok;
    logic                mul_start, mul_done;
    logic [SIZE-1:0]     mul_result;

    // The modulus exceeds 2^(SIZE-1), so one subtract fully reduces any SIZE-bit seed.
    always_comb begin
        seed_red = (seed >= MOD_S) ? seed - MOD_S : seed;
        seed_ok  = seed_red > SIZE'(1);
    end

    mod_mul_serial #(
        .SIZE (SIZE),
        .MOD  (MOD)
    ) u_mul (
        .clk    (clk),
        .reset  (reset),
        .start  (mul_start),
        .a      (x_q),
        .b      (x_q),
        .done   (mul_done),
        .result (mul_result)
    );

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        word_d    = word_q;
        bitcnt_d  = bitcnt_q;
        valid_d   = valid_q;
        err_d     = 1'b0;
        mul_start = 1'b0;

        if (seed_load) begin
            // Reseed takes priority over everything, including a same-cycle out_ready.
            bitcnt_d = '0;
            valid_d  = 1'b0;
            word_d   = '0;
            if (seed_ok) begin
                x_d       = seed_red;
                state_d   = ST_MUL;
                mul_start = 1'b1;
            end else begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_MUL: begin
                    if (mul_done) begin
                        state_d = ST_WB;
                    end
                end
                ST_WB: begin
                    x_d = mul_result;
                    for (int unsigned i = 0; i < OUT_BITS; i++) begin
                        if (bitcnt_q == CW'(i)) begin
                            word_d[i] = mul_result[0];
                        end
                    end
                    bitcnt_d = bitcnt_q + CW'(1);
                    if (bitcnt_d == CW'(OUT_BITS)) begin
                        state_d = ST_HOLD;
                        valid_d = 1'b1;
                    end else begin
                        state_d   = ST_MUL;
                        mul_start = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        valid_d   = 1'b0;
                        bitcnt_d  = '0;
                        state_d   = ST_MUL;
                        mul_start = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            word_q   <= '0;
            bitcnt_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            word_q   <= word_d;
            bitcnt_q <= bitcnt_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign out_word  = word_q;
    assign out_valid = valid_q;
    assign busy      = (state_q == ST_MUL) || (state_q == ST_WB);
    assign seed_err  = err_q;
    assign state_out = x_q;

endmodule

// File: tb/tb_bbs_stream_gen.sv
// Directed bench for bbs_stream_gen: a default instance (8-bit words) and an
// OUT_BITS=2 instance, checked against hand-computed values and a BBS model.
module tb_bbs_stream_gen;

    logic        clk = 1'b0;
    logic        reset;

    logic [15:0] seed, seed2;
    logic        ld, ld2, rdy, rdy2;
    logic [7:0]  word;
    logic [1:0]  word2;
    logic        valid, valid2, busy, busy2, err, err2;
    logic [15:0] xo, xo2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bbs_stream_gen #(.SIZE(16), .MOD(40633), .OUT_BITS(8)) dut (
        .clk(clk), .reset(reset), .seed(seed), .seed_load(ld), .out_ready(rdy),
        .out_word(word), .out_valid(valid), .busy(busy), .seed_err(err),
        .state_out(xo)
    );

    bbs_stream_gen #(.SIZE(16), .MOD(40633), .OUT_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .seed(seed2), .seed_load(ld2), .out_ready(rdy2),
        .out_word(word2), .out_valid(valid2), .busy(busy2), .seed_err(err2),
        .state_out(xo2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned bbs_next(input int unsigned x);
        return (x * x) % 40633;
    endfunction

    int unsigned mx;
    logic [7:0]  ew;
    logic [1:0]  ew2;
    int          n, last, words, bad;

    initial begin
        reset = 1'b1;
        seed = '0; ld = 1'b0; rdy = 1'b0;
        seed2 = '0; ld2 = 1'b0; rdy2 = 1'b0;
        tick(); tick();
        check_eq("rst_x", xo, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_valid", valid, 0);
        check_eq("rst_word", word, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_valid2", valid2, 0);
        reset = 1'b0;
        tick();

        // Reset in the middle of MUL
        seed = 16'd200; ld = 1'b1; tick(); ld = 1'b0;
        check_eq("load_busy", busy, 1);
        check_eq("load_x", xo, 200);
        repeat (5) tick();
        reset = 1'b1; #1;
        check_eq("midrst_x", xo, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_valid", valid, 0);
        check_eq("midrst_err", err, 0);
        tick(); reset = 1'b0; tick();

        // Clean run from seed 200
        seed = 16'd200; ld = 1'b1; tick(); ld = 1'b0;
        n = 0; bad = 0;
        while (!valid && n < 300) begin
            tick(); n++;
            if (n == 16) check_eq("x0_hold", xo, 200);
            if (n == 17) check_eq("x1_200", xo, 40000);
            if (n == 34) check_eq("x2_200", xo, 34992);
            if (!valid && !busy) bad++;
        end
        check_eq("first_valid_lat", n, 136);
        check_eq("busy_gaps", bad, 0);
        mx = 200;
        for (int k = 0; k < 8; k++) begin mx = bbs_next(mx); ew[k] = mx[0]; end
        check_eq("word_200", word, ew);
        check_eq("hold_busy", busy, 0);
        check_eq("hold_x", xo, mx);

        // Reseed 884 in HOLD with out_ready in the same cycle
        rdy = 1'b1; seed = 16'd884; ld = 1'b1; tick(); ld = 1'b0; rdy = 1'b0;
        check_eq("reseed_valid", valid, 0);
        check_eq("reseed_busy", busy, 1);
        repeat (17) tick();
        check_eq("x1_884", xo, 9429);

        // Rejected seeds
        seed = 16'd40634; ld = 1'b1; tick(); ld = 1'b0;
        check_eq("rej1_err", err, 1);
        check_eq("rej1_busy", busy, 0);
        check_eq("rej1_valid", valid, 0);
        check_eq("rej1_x", xo, 9429);
        tick();
        check_eq("rej1_pulse", err, 0);
        seed = 16'd40633; ld = 1'b1; tick(); ld = 1'b0;
        check_eq("rej0_err", err, 1);
        check_eq("rej0_busy", busy, 0);
        tick();
        check_eq("rej0_pulse", err, 0);
        repeat (20) tick();
        check_eq("rej_idle_busy", busy, 0);
        check_eq("rej_idle_x", xo, 9429);

        // OUT_BITS=2 instance
        seed2 = 16'd40600; ld2 = 1'b1; tick(); ld2 = 1'b0;
        n = 0;
        while (!valid2 && n < 100) begin tick(); n++; end
        check_eq("w2_lat", n, 34);
        check_eq("w2_word", word2, 2'b01);
        check_eq("w2_x", xo2, 7564);
        bad = 0;
        repeat (10) begin
            tick();
            if (!valid2 || word2 != 2'b01 || xo2 != 16'd7564 || busy2) bad++;
        end
        check_eq("w2_hold_stable", bad, 0);
        rdy2 = 1'b1; tick(); rdy2 = 1'b0;
        check_eq("w2_ack_valid", valid2, 0);
        check_eq("w2_ack_busy", busy2, 1);
        mx = 7564;
        for (int k = 0; k < 2; k++) begin mx = bbs_next(mx); ew2[k] = mx[0]; end
        n = 0;
        while (!valid2 && n < 100) begin tick(); n++; end
        check_eq("w2b_lat", n, 34);
        check_eq("w2b_word", word2, ew2);
        check_eq("w2b_x", xo2, mx);

        rdy2 = 1'b1; seed2 = 16'd884; ld2 = 1'b1; tick(); ld2 = 1'b0; rdy2 = 1'b0;
        check_eq("w2_reseed_valid", valid2, 0);
        mx = 884;
        for (int k = 0; k < 2; k++) begin mx = bbs_next(mx); ew2[k] = mx[0]; end
        n = 0;
        while (!valid2 && n < 100) begin
            tick(); n++;
            if (n == 17) check_eq("w2_x1_884", xo2, 9429);
        end
        check_eq("w2c_lat", n, 34);
        check_eq("w2c_word", word2, ew2);

        // Back-to-back words with out_ready tied high
        rdy = 1'b1; seed = 16'd200; ld = 1'b1; tick(); ld = 1'b0;
        mx = 200; n = 0; last = 0; words = 0;
        while (words < 64 && n < 64 * 137 + 300) begin
            tick(); n++;
            if (valid) begin
                for (int k = 0; k < 8; k++) begin mx = bbs_next(mx); ew[k] = mx[0]; end
                check_eq("b2b_word", word, ew);
                check_eq("b2b_x", xo, mx);
                if (words == 0) check_eq("b2b_first", n, 136);
                else            check_eq("b2b_gap", n - last, 137);
                last = n;
                words++;
            end
        end
        check_eq("b2b_count", words, 64);
        rdy = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bbs_stream_gen.md
Name: bbs_stream_gen

Overview:
- Blum Blum Shub pseudo-random bit generator.
- Iterates x(n+1) = x(n)^2 mod MOD using a bit-serial interleaved modular multiplier: one multiplier bit per clock, no wide combinational loop.
- Collects the LSB of each new state into an OUT_BITS-wide word and hands it out over a valid/ready handshake.
- Sits between the seed source (buttons/switches or a host register) and consumers such as the hex display path.

Parameters:
- SIZE, 16: state/modulus width in bits.
- MOD, 40633: Blum modulus (179*227, both primes ≡ 3 mod 4). Constraint: 2^(SIZE-1) < MOD < 2^SIZE, so any SIZE-bit seed needs at most one subtraction to reduce.
- OUT_BITS, 8: generated bits per output word, 1..32.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- seed  input  SIZE  seed value, sampled when seed_load=1.
- seed_load  input  1  single-cycle load strobe; accepted in any state.
- out_ready  input  1  consumer accepts out_word.
- out_word  output  OUT_BITS  generated word; first-generated bit in bit 0.
- out_valid  output  1  out_word valid.
- busy  output  1  generator iterating (states MUL/WB).
- seed_err  output  1  one-cycle pulse: rejected seed.
- state_out  output  SIZE  current x(n), for debug/verification.

Behaviour:
- Reset values (async, immediate): state IDLE; out_word=0, out_valid=0, busy=0, seed_err=0, state_out=0; bit counter=0; accumulator=0.
- Seed reduction: s = seed - MOD if seed >= MOD, else seed.
  - s == 0 or s == 1: seed_err pulses the next cycle; FSM goes to or stays in IDLE; state_out unchanged.
  - Otherwise: state_out <= s, bit counter <= 0, out_valid <= 0, go to MUL.
- FSM states:
  - IDLE: wait for seed_load.
  - MUL: SIZE cycles, index i = SIZE-1 down to 0. Each cycle acc = (2*acc) mod MOD, then if x[i] then acc = (acc + x) mod MOD. Both reductions are single conditional subtracts on a SIZE+1-bit acc. acc is cleared on MUL entry.
  - WB, 1 cycle:
    - state_out <= acc.
    - out_word[bitcnt] <= acc[0].
    - bitcnt++.
    - If bitcnt reaches OUT_BITS: go to HOLD with out_valid=1. Else go to MUL.
  - HOLD: out_valid=1, out_word stable, no computation. On out_ready: out_valid=0, bitcnt=0, go to MUL next cycle.
- Latency:
  - One iteration = SIZE+1 cycles; state_out updates SIZE+1 cycles after MUL entry.
  - First out_valid rises OUT_BITS*(SIZE+1) cycles after seed acceptance (136 with defaults).
- busy is high exactly in MUL and WB.
- seed_load while busy or in HOLD: aborts the current iteration, discards the partial or held word, drops out_valid, restarts from the new seed (or rejects it as above).
- seed_load and out_ready in the same HOLD cycle: seed wins; the word is not counted as transferred.
- out_ready outside HOLD: ignored.
- The sequence runs indefinitely until reseed or reset; x never reaches 0 for valid seeds, so no special wrap handling is needed.
- Reset asserted mid-iteration: immediate return to reset values; the next seed_load starts cleanly.

Decomposition:
- Package bbs_pkg:
  - FSM state encoding (IDLE, MUL, WB, HOLD).
  - Default SIZE/MOD constants.
  - Helper for the bit-counter width, clog2(OUT_BITS+1).
- Sub-module mod_mul_serial (parameters SIZE, MOD):
  - Ports: start, operand a, operand b, done, result.
  - Computes a*b mod MOD in SIZE cycles. Instantiated here with a=b=x.
  - Reusable later for general modular exponentiation.
- Top: FSM, seed reduction, bit collector, handshake.

Test Plan:
- Reset mid-MUL (assert reset 5 cycles after seed 200): all outputs 0 immediately. Reload seed 200 → state_out=40000 after 17 cycles.
- Seed 200, defaults: state_out=40000 at +17 cycles and 34992 at +34; busy high throughout; out_valid rises at +136.
- OUT_BITS=2, seed 40600: x1=1089, x2=7564 → out_word=2'b01 with out_valid at +34. Hold out_ready=0 for 10 cycles: word and valid stable, state_out stays 7564. Pulse out_ready → out_valid=0, busy=1 next cycle.
- Seed 884: state_out=9429 at +17. Seed 40634 (reduces to 1) and seed 40633 (reduces to 0): each gives a seed_err single-cycle pulse, FSM stays IDLE, busy=0.
- Reseed 884 during HOLD with out_ready=1 in the same cycle: out_valid drops, word discarded, state_out=9429 after 17 cycles. A later word is produced normally.
- Back-to-back: with out_ready tied high, consecutive out_valid pulses are spaced exactly OUT_BITS*(SIZE+1)+1 cycles apart. The bit stream matches a software BBS model for 64 words.
